// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall patterns, the
// stop/no-stop levels and the redirect-target selection.
package pipe_ctrl_pkg;

    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // stall[5:0] = {WB, MEM, EX, ID, IF, PC}; a request stops its own stage
    // and everything upstream of it.
    localparam logic [5:0]  StallMem  = 6'b011111;
    localparam logic [5:0]  StallEx   = 6'b001111;
    localparam logic [5:0]  StallId   = 6'b000111;
    localparam logic [5:0]  StallIf   = 6'b000011;
    localparam logic [5:0]  StallNone = 6'b000000;

    // eret returns to EPC; every other exception enters the common vector.
    function automatic logic [31:0] redirect_target(input logic        is_eret,
                                                    input logic [31:0] epc,
                                                    input logic [31:0] vector);
        return is_eret ? epc : vector;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// Priority encoder from the four per-stage stall requests to the stall
// vector. The deepest requesting stage wins; a flush suppresses all stalls.
module stall_encoder
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_if,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    input  logic       stallreq_mem,
    input  logic       flushing,
    output logic [5:0] stall
);

    // Combinational priority select, gated off while flushing
    always_comb begin
        stall = StallNone;
        if (!flushing) begin
            if (stallreq_mem)     stall = StallMem;
            else if (stallreq_ex) stall = StallEx;
            else if (stallreq_id) stall = StallId;
            else if (stallreq_if) stall = StallIf;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests and sequences exception /
// eret redirects through a registered flush that holds until fetch is free.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        except_valid,
    input  logic        except_eret,
    input  logic [31:0] cp0_epc,
    input  logic        if_busy,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        WAIT_IF = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic       accept;

    // An exception is only taken when idle and MEM is not holding; a
    // MEM-stalled exception is re-presented once the stall clears.
    assign accept = (state == IDLE) && except_valid && !stallreq_mem;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Flush-length counter and latched redirect target
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 4'd0;
            new_pc <= ZeroWord;
        end else if (accept) begin
            cnt    <= CNT_LOAD;
            new_pc <= redirect_target(except_eret, cp0_epc, EXC_VECTOR);
        end else if (state == FLUSH && cnt != 4'd0) begin
            cnt    <= cnt - 4'd1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = FLUSH;
            FLUSH:   if (cnt == 4'd0) next_state = if_busy ? WAIT_IF : IDLE;
            WAIT_IF: if (!if_busy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Flush is decoded from the state register, so it is glitch-free and
    // starts the cycle after acceptance.
    always_comb begin
        flush = NoStop;
        if (state == FLUSH || state == WAIT_IF) flush = Stop;
    end

    stall_encoder u_stall_encoder (
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .flushing     (flush),
        .stall        (stall)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: each row drives one cycle of inputs and queues the
// outputs expected for that same cycle; the row is popped and checked at
// the falling edge. A second instance covers FLUSH_CYCLES=3.
module tb_pipe_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam logic [31:0] EPC = 32'h8000_1234;

    // req = {mem, ex, id, if}
    typedef struct packed {
        logic [3:0]  req;
        logic        ev;
        logic        er;
        logic        ib;
        logic        rst;
        logic [5:0]  es;
        logic        ef;
        logic [31:0] ep;
        logic        cp;
    } row_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        except_valid = 1'b0, except_eret = 1'b0, if_busy = 1'b0;
    logic [31:0] cp0_epc = EPC;
    logic [5:0]  stall, stall3;
    logic        flush, flush3;
    logic [31:0] new_pc, new_pc3;

    row_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .reset(reset),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .except_valid(except_valid), .except_eret(except_eret),
        .cp0_epc(cp0_epc), .if_busy(if_busy),
        .stall(stall), .flush(flush), .new_pc(new_pc)
    );

    pipe_ctrl #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .except_valid(except_valid), .except_eret(except_eret),
        .cp0_epc(cp0_epc), .if_busy(if_busy),
        .stall(stall3), .flush(flush3), .new_pc(new_pc3)
    );

    function automatic row_t mk(input logic [3:0] req, input logic ev, input logic er,
                                input logic ib, input logic rst, input logic [5:0] es,
                                input logic ef, input logic [31:0] ep, input logic cp);
        row_t r;
        r.req = req; r.ev = ev; r.er = er; r.ib = ib; r.rst = rst;
        r.es = es; r.ef = ef; r.ep = ep; r.cp = cp;
        return r;
    endfunction

    // Apply one cycle of stimulus just after the rising edge and queue its expectation
    task automatic drive(input row_t r);
        @(posedge clk); #1;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = r.req;
        except_valid = r.ev;
        except_eret  = r.er;
        if_busy      = r.ib;
        reset        = r.rst;
        sbq.push_back(r);
    endtask

    task automatic test_reset();
        row_t r[$];
        row_t e;
        r.push_back(mk(4'b0000, 0, 0, 0, 1, 6'b000000, 0, 32'h0, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 32'h0, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 32'h0, 1));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (stall !== e.es || flush !== e.ef || (e.cp && new_pc !== e.ep)) begin
                n_bad++;
                $display("FAIL reset[%0d] got stall=%b flush=%b new_pc=%h want stall=%b flush=%b new_pc=%h",
                         i, stall, flush, new_pc, e.es, e.ef, e.ep);
            end
        end
    endtask

    task automatic test_stall_priority();
        row_t r[$];
        row_t e;
        r.push_back(mk(4'b0110, 0, 0, 0, 0, 6'b001111, 0, 32'h0, 1));
        r.push_back(mk(4'b1110, 0, 0, 0, 0, 6'b011111, 0, 32'h0, 1));
        r.push_back(mk(4'b0001, 0, 0, 0, 0, 6'b000011, 0, 32'h0, 1));
        r.push_back(mk(4'b0011, 0, 0, 0, 0, 6'b000111, 0, 32'h0, 1));
        r.push_back(mk(4'b1001, 0, 0, 0, 0, 6'b011111, 0, 32'h0, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 32'h0, 1));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (stall !== e.es || flush !== e.ef || (e.cp && new_pc !== e.ep)) begin
                n_bad++;
                $display("FAIL stall_prio[%0d] got stall=%b flush=%b new_pc=%h want stall=%b flush=%b new_pc=%h",
                         i, stall, flush, new_pc, e.es, e.ef, e.ep);
            end
        end
    endtask

    task automatic test_exception();
        row_t r[$];
        row_t e;
        r.push_back(mk(4'b0000, 1, 0, 0, 0, 6'b000000, 0, 32'h0, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 1, VEC,   1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, VEC,   1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, VEC,   1));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (stall !== e.es || flush !== e.ef || (e.cp && new_pc !== e.ep)) begin
                n_bad++;
                $display("FAIL exception[%0d] got stall=%b flush=%b new_pc=%h want stall=%b flush=%b new_pc=%h",
                         i, stall, flush, new_pc, e.es, e.ef, e.ep);
            end
        end
    endtask

    // eret arrives together with an IF stall: accepted, stall still shown that cycle
    task automatic test_eret();
        row_t r[$];
        row_t e;
        r.push_back(mk(4'b0001, 1, 1, 0, 0, 6'b000011, 0, VEC, 1));
        r.push_back(mk(4'b0001, 0, 0, 0, 0, 6'b000000, 1, EPC, 1));
        r.push_back(mk(4'b0001, 0, 0, 0, 0, 6'b000011, 0, EPC, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, EPC, 1));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (stall !== e.es || flush !== e.ef || (e.cp && new_pc !== e.ep)) begin
                n_bad++;
                $display("FAIL eret[%0d] got stall=%b flush=%b new_pc=%h want stall=%b flush=%b new_pc=%h",
                         i, stall, flush, new_pc, e.es, e.ef, e.ep);
            end
        end
    endtask

    // Fetch busy holds flush; an eret offered mid-flush must not overwrite new_pc
    task automatic test_fetch_busy();
        row_t r[$];
        row_t e;
        r.push_back(mk(4'b0000, 1, 0, 1, 0, 6'b000000, 0, EPC, 1));
        r.push_back(mk(4'b0001, 0, 0, 1, 0, 6'b000000, 1, VEC, 1));
        r.push_back(mk(4'b0001, 1, 1, 1, 0, 6'b000000, 1, VEC, 1));
        r.push_back(mk(4'b0001, 1, 1, 0, 0, 6'b000000, 1, VEC, 1));
        r.push_back(mk(4'b0001, 0, 0, 0, 0, 6'b000011, 0, VEC, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, VEC, 1));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (stall !== e.es || flush !== e.ef || (e.cp && new_pc !== e.ep)) begin
                n_bad++;
                $display("FAIL fetch_busy[%0d] got stall=%b flush=%b new_pc=%h want stall=%b flush=%b new_pc=%h",
                         i, stall, flush, new_pc, e.es, e.ef, e.ep);
            end
        end
    endtask

    task automatic test_mem_stall();
        row_t r[$];
        row_t e;
        r.push_back(mk(4'b1000, 1, 1, 0, 0, 6'b011111, 0, VEC, 1));
        r.push_back(mk(4'b0000, 1, 1, 0, 0, 6'b000000, 0, VEC, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 1, EPC, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, EPC, 1));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (stall !== e.es || flush !== e.ef || (e.cp && new_pc !== e.ep)) begin
                n_bad++;
                $display("FAIL mem_stall[%0d] got stall=%b flush=%b new_pc=%h want stall=%b flush=%b new_pc=%h",
                         i, stall, flush, new_pc, e.es, e.ef, e.ep);
            end
        end
    endtask

    // Accept, ignore one offered during the flush pulse, accept again at N+2
    task automatic test_back_to_back();
        row_t r[$];
        row_t e;
        r.push_back(mk(4'b0000, 1, 0, 0, 0, 6'b000000, 0, EPC, 1));
        r.push_back(mk(4'b0000, 1, 1, 0, 0, 6'b000000, 1, VEC, 1));
        r.push_back(mk(4'b0000, 1, 1, 0, 0, 6'b000000, 0, VEC, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 1, EPC, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, EPC, 1));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (stall !== e.es || flush !== e.ef || (e.cp && new_pc !== e.ep)) begin
                n_bad++;
                $display("FAIL back_to_back[%0d] got stall=%b flush=%b new_pc=%h want stall=%b flush=%b new_pc=%h",
                         i, stall, flush, new_pc, e.es, e.ef, e.ep);
            end
        end
    endtask

    // Reset while waiting on fetch drops the pending redirect
    task automatic test_reset_wait_if();
        row_t r[$];
        row_t e;
        r.push_back(mk(4'b0000, 1, 0, 1, 0, 6'b000000, 0, EPC,   1));
        r.push_back(mk(4'b0000, 0, 0, 1, 0, 6'b000000, 1, VEC,   1));
        r.push_back(mk(4'b0000, 0, 0, 1, 1, 6'b000000, 1, VEC,   1));
        r.push_back(mk(4'b0001, 0, 0, 1, 0, 6'b000011, 0, 32'h0, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 32'h0, 1));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (stall !== e.es || flush !== e.ef || (e.cp && new_pc !== e.ep)) begin
                n_bad++;
                $display("FAIL reset_wait_if[%0d] got stall=%b flush=%b new_pc=%h want stall=%b flush=%b new_pc=%h",
                         i, stall, flush, new_pc, e.es, e.ef, e.ep);
            end
        end
    endtask

    // FLUSH_CYCLES=3 instance: three-cycle flush, then reset in the 2nd flush cycle
    task automatic test_flush3();
        row_t r[$];
        row_t e;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        r.push_back(mk(4'b0000, 1, 0, 0, 0, 6'b000000, 0, 32'h0, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 1, VEC,   1));
        r.push_back(mk(4'b0010, 0, 0, 0, 0, 6'b000000, 1, VEC,   1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 1, VEC,   1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, VEC,   1));
        r.push_back(mk(4'b0000, 1, 1, 0, 0, 6'b000000, 0, VEC,   1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 1, EPC,   1));
        r.push_back(mk(4'b0000, 0, 0, 0, 1, 6'b000000, 1, EPC,   1));
        r.push_back(mk(4'b0001, 0, 0, 0, 0, 6'b000011, 0, 32'h0, 1));
        r.push_back(mk(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 32'h0, 1));
        foreach (r[i]) begin
            drive(r[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (stall3 !== e.es || flush3 !== e.ef || (e.cp && new_pc3 !== e.ep)) begin
                n_bad++;
                $display("FAIL flush3[%0d] got stall=%b flush=%b new_pc=%h want stall=%b flush=%b new_pc=%h",
                         i, stall3, flush3, new_pc3, e.es, e.ef, e.ep);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall_priority();
        test_exception();
        test_eret();
        test_fetch_busy();
        test_mem_stall();
        test_back_to_back();
        test_reset_wait_if();
        test_flush3();
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d left want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
